input_event_conditioner: RTL and testbench

Parametrised, multi-channel front end for board buttons, switches and FPGA-side reset-request lines. Each channel is synchronised and debounced to a polarity-normalised level. Enabled rising and falling edges then produce a stretched pulse and a sticky pending flag, and all channels share one interrupt. It sits between the raw `KEY`/`SW`/source-probe inputs and the HPS-facing logic: STM hardware events, the f2h reset requests and the GPIO interrupt inputs.

---
 rtl/input_conditioner_pkg.sv | 20 ++
 rtl/ic_channel.sv | 90 +++++++++
 rtl/input_event_conditioner.sv | 47 ++++
 tb/tb_input_event_conditioner.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/input_conditioner_pkg.sv
// Shared helpers for the input event conditioner: raw idle level, counter sizing and
// elaboration-time parameter legality.
package input_conditioner_pkg;

  function automatic logic inactive_raw_level(input bit active_low);
    return active_low ? 1'b1 : 1'b0;
  endfunction

  // Bits needed to hold values 0..max_val inclusive.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

  function automatic bit params_legal(input int unsigned sync_stages,
                                      input int unsigned timeout,
                                      input int unsigned pulse_ext);
    return (sync_stages >= 2) && (timeout >= 1) && (pulse_ext >= 1);
  endfunction

endpackage

// File: rtl/ic_channel.sv
// One conditioner channel: synchroniser, debounce, edge qualify, pulse stretch and
// sticky pending flag.
module ic_channel
  import input_conditioner_pkg::*;
#(
  parameter bit          ACTIVE_LOW  = 1'b1,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TIMEOUT     = 50000,
  parameter int unsigned PULSE_EXT   = 4,
  parameter bit          RETRIGGER   = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic data_in,
  input  logic rise_en,
  input  logic fall_en,
  input  logic ev_clr,
  output logic level_out,
  output logic pulse_out,
  output logic event_pending
);

  localparam int unsigned     DbW     = cnt_width(TIMEOUT);
  localparam int unsigned     PlW     = cnt_width(PULSE_EXT);
  localparam logic [DbW-1:0] DbLast  = DbW'(TIMEOUT - 1);
  localparam logic [PlW-1:0] PlLoad  = PlW'(PULSE_EXT);
  localparam logic            RawIdle = inactive_raw_level(ACTIVE_LOW);

  if (!params_legal(SYNC_STAGES, TIMEOUT, PULSE_EXT)) begin : gen_param_check
    $error("ic_channel: need SYNC_STAGES>=2, TIMEOUT>=1, PULSE_EXT>=1");
  end

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [DbW-1:0]         db_cnt_q, db_cnt_d;
  logic [PlW-1:0]         pl_cnt_q, pl_cnt_d;
  logic                   level_q, level_d;
  logic                   pend_q, pend_d;
  logic                   s, rise, fall, ev;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], data_in};
    s      = ACTIVE_LOW ? ~sync_q[SYNC_STAGES-1] : sync_q[SYNC_STAGES-1];

    // Any cycle agreeing with the current level restarts the stability count.
    level_d  = level_q;
    db_cnt_d = '0;
    if (s != level_q) begin
      if (db_cnt_q == DbLast) begin
        level_d = s;
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end

    rise = level_d & ~level_q;
    fall = ~level_d & level_q;
    ev   = (rise & rise_en) | (fall & fall_en);

    pl_cnt_d = pl_cnt_q;
    if (ev && ((pl_cnt_q == '0) || RETRIGGER)) begin
      pl_cnt_d = PlLoad;
    end else if (pl_cnt_q != '0) begin
      pl_cnt_d = pl_cnt_q - 1'b1;
    end

    // A new event in the same cycle as a clear keeps the flag set.
    pend_d = (pend_q & ~ev_clr) | ev;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q   <= {SYNC_STAGES{RawIdle}};
      db_cnt_q <= '0;
      level_q  <= 1'b0;
      pl_cnt_q <= '0;
      pend_q   <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      db_cnt_q <= db_cnt_d;
      level_q  <= level_d;
      pl_cnt_q <= pl_cnt_d;
      pend_q   <= pend_d;
    end
  end

  assign level_out     = level_q;
  assign pulse_out     = (pl_cnt_q != '0);
  assign event_pending = pend_q;

endmodule

// File: rtl/input_event_conditioner.sv
// Multi-channel button/switch/reset-request conditioner with a shared interrupt built
// from the per-channel sticky pending flags.
module input_event_conditioner
  import input_conditioner_pkg::*;
#(
  parameter int unsigned WIDTH       = 4,
  parameter bit          ACTIVE_LOW  = 1'b1,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TIMEOUT     = 50000,
  parameter int unsigned PULSE_EXT   = 4,
  parameter bit          RETRIGGER   = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] data_in,
  input  logic [WIDTH-1:0] rise_en,
  input  logic [WIDTH-1:0] fall_en,
  input  logic [WIDTH-1:0] ev_clr,
  output logic [WIDTH-1:0] level_out,
  output logic [WIDTH-1:0] pulse_out,
  output logic [WIDTH-1:0] event_pending,
  output logic             irq
);

  for (genvar i = 0; i < WIDTH; i++) begin : gen_ch
    ic_channel #(
      .ACTIVE_LOW  (ACTIVE_LOW),
      .SYNC_STAGES (SYNC_STAGES),
      .TIMEOUT     (TIMEOUT),
      .PULSE_EXT   (PULSE_EXT),
      .RETRIGGER   (RETRIGGER)
    ) u_ch (
      .clk           (clk),
      .rst_n         (rst_n),
      .data_in       (data_in[i]),
      .rise_en       (rise_en[i]),
      .fall_en       (fall_en[i]),
      .ev_clr        (ev_clr[i]),
      .level_out     (level_out[i]),
      .pulse_out     (pulse_out[i]),
      .event_pending (event_pending[i])
    );
  end

  assign irq = |event_pending;

endmodule

// File: tb/tb_input_event_conditioner.sv
// Self-checking bench: directed scenarios plus randomized traffic against an
// event-time reference model of the main two-channel instance.
module tb_input_event_conditioner;

  localparam int T = 8;
  localparam int P = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [1:0] data_in = 2'b11, rise_en = 2'b11, fall_en = 2'b11, ev_clr = 2'b00;
  logic [1:0] level_out, pulse_out, event_pending;
  logic       irq;

  logic [1:0] r_data = 2'b11;
  logic [1:0] r1_level, r1_pulse, r1_pend, r0_level, r0_pulse, r0_pend;
  logic       r1_irq, r0_irq;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  input_event_conditioner #(
    .WIDTH(2), .ACTIVE_LOW(1'b1), .SYNC_STAGES(2), .TIMEOUT(T), .PULSE_EXT(P),
    .RETRIGGER(1'b1)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .rise_en(rise_en), .fall_en(fall_en),
    .ev_clr(ev_clr), .level_out(level_out), .pulse_out(pulse_out),
    .event_pending(event_pending), .irq(irq)
  );

  input_event_conditioner #(
    .WIDTH(2), .ACTIVE_LOW(1'b1), .SYNC_STAGES(2), .TIMEOUT(2), .PULSE_EXT(20),
    .RETRIGGER(1'b1)
  ) u_dut_rt1 (
    .clk(clk), .rst_n(rst_n), .data_in(r_data), .rise_en(2'b11), .fall_en(2'b11),
    .ev_clr(2'b00), .level_out(r1_level), .pulse_out(r1_pulse),
    .event_pending(r1_pend), .irq(r1_irq)
  );

  input_event_conditioner #(
    .WIDTH(2), .ACTIVE_LOW(1'b1), .SYNC_STAGES(2), .TIMEOUT(2), .PULSE_EXT(20),
    .RETRIGGER(1'b0)
  ) u_dut_rt0 (
    .clk(clk), .rst_n(rst_n), .data_in(r_data), .rise_en(2'b11), .fall_en(2'b11),
    .ev_clr(2'b00), .level_out(r0_level), .pulse_out(r0_pulse),
    .event_pending(r0_pend), .irq(r0_irq)
  );

  // Reference model: raw samples reach the debouncer two edges late; a level flips on the
  // T-th consecutive disagreeing edge; a pulse lasts until an absolute edge number.
  logic [1:0] m_pipe[$];
  int         m_edge;
  int         m_run[2];
  bit         m_level[2];
  bit         m_pend[2];
  int         m_pulse_end[2];

  task automatic model_reset();
    m_pipe = {2'b11, 2'b11};
    m_edge = 0;
    for (int c = 0; c < 2; c++) begin
      m_run[c] = 0; m_level[c] = 0; m_pend[c] = 0; m_pulse_end[c] = 0;
    end
  endtask

  task automatic model_edge();
    logic [1:0] s_vec;
    bit nl, ev;
    m_edge++;
    s_vec = ~m_pipe.pop_front();
    m_pipe.push_back(data_in);
    for (int c = 0; c < 2; c++) begin
      nl = m_level[c];
      if (s_vec[c] != m_level[c]) begin
        m_run[c]++;
        if (m_run[c] == T) begin
          nl = s_vec[c];
          m_run[c] = 0;
        end
      end else begin
        m_run[c] = 0;
      end
      ev = (nl && !m_level[c] && rise_en[c]) || (!nl && m_level[c] && fall_en[c]);
      if (ev) m_pulse_end[c] = m_edge + P;
      m_pend[c] = (m_pend[c] && !ev_clr[c]) || ev;
      m_level[c] = nl;
    end
  endtask

  function automatic logic [1:0] m_level_vec();
    return {m_level[1], m_level[0]};
  endfunction

  function automatic logic [1:0] m_pulse_vec();
    return {logic'(m_edge < m_pulse_end[1]), logic'(m_edge < m_pulse_end[0])};
  endfunction

  function automatic logic [1:0] m_pend_vec();
    return {m_pend[1], m_pend[0]};
  endfunction

  task automatic step();
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_edge();
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    #10;
    n_checks++;
    if ({level_out, pulse_out, event_pending, irq} !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_outputs got=%b want=0", {level_out, pulse_out, event_pending, irq});
    end
    @(posedge clk);
    #3 rst_n = 1'b1;
    for (int k = 0; k < 4; k++) step();
    n_checks++;
    if ({level_out, pulse_out, event_pending, irq} !== 7'b0) begin
      n_fail++;
      $display("FAIL idle_after_reset got=%b want=0", {level_out, pulse_out, event_pending, irq});
    end
  endtask

  task automatic test_clean_press();
    data_in = 2'b10;
    for (int n = 1; n <= 14; n++) begin
      step();
      n_checks++;
      if (level_out !== {1'b0, logic'(n >= 10)}) begin
        n_fail++;
        $display("FAIL press_level edge=%0d got=%b want=%b", n, level_out, {1'b0, n >= 10});
      end
      n_checks++;
      if (pulse_out !== {1'b0, logic'(n >= 10 && n <= 12)}) begin
        n_fail++;
        $display("FAIL press_pulse edge=%0d got=%b", n, pulse_out);
      end
    end
    n_checks++;
    if ({event_pending, irq} !== 3'b011) begin
      n_fail++;
      $display("FAIL press_pending got=%b want=011", {event_pending, irq});
    end
  endtask

  task automatic test_disabled_fall();
    fall_en = 2'b10;
    data_in = 2'b11;
    for (int n = 1; n <= 14; n++) begin
      step();
      n_checks++;
      if (level_out[0] !== logic'(n < 10)) begin
        n_fail++;
        $display("FAIL dis_fall_level edge=%0d got=%b want=%b", n, level_out[0], n < 10);
      end
      n_checks++;
      if (pulse_out !== 2'b00) begin
        n_fail++;
        $display("FAIL dis_fall_pulse edge=%0d got=%b want=00", n, pulse_out);
      end
    end
    n_checks++;
    if (event_pending !== 2'b01) begin
      n_fail++;
      $display("FAIL dis_fall_pending got=%b want=01", event_pending);
    end
    fall_en = 2'b11;
  endtask

  task automatic test_bounce();
    int rises = 0;
    for (int c = 0; c < 30; c++) begin
      data_in[0] = ((c / 3) % 2 == 0) ? 1'b0 : 1'b1;
      step();
      n_checks++;
      if (level_out[0] !== 1'b0) begin
        n_fail++;
        $display("FAIL bounce_level cyc=%0d got=%b want=0", c, level_out[0]);
      end
    end
    data_in[0] = 1'b0;
    for (int n = 1; n <= 12; n++) begin
      step();
      if (pulse_out[0] && n == 10) rises++;
      n_checks++;
      if (level_out[0] !== logic'(n >= 10)) begin
        n_fail++;
        $display("FAIL bounce_settle edge=%0d got=%b want=%b", n, level_out[0], n >= 10);
      end
    end
    n_checks++;
    if (rises != 1) begin
      n_fail++;
      $display("FAIL bounce_rise_count got=%0d want=1", rises);
    end
  endtask

  task automatic test_clear();
    data_in[0] = 1'b1;
    for (int n = 1; n <= 10; n++) begin
      if (n == 10) ev_clr = 2'b01;
      step();
    end
    ev_clr = 2'b00;
    n_checks++;
    if ({level_out[0], pulse_out[0], event_pending[0]} !== 3'b011) begin
      n_fail++;
      $display("FAIL clear_vs_set got=%b want=011",
               {level_out[0], pulse_out[0], event_pending[0]});
    end
    step();
    n_checks++;
    if (event_pending !== 2'b01) begin
      n_fail++;
      $display("FAIL clear_hold got=%b want=01", event_pending);
    end
    ev_clr = 2'b01;
    step();
    ev_clr = 2'b00;
    n_checks++;
    if ({event_pending, irq} !== 3'b000) begin
      n_fail++;
      $display("FAIL clear_lone got=%b want=000", {event_pending, irq});
    end
  endtask

  task automatic test_retrigger();
    int k_rise = -1;
    int hi1 = 0, hi0 = 0, up1 = 0, up0 = 0;
    logic p1 = 1'b0, p0 = 1'b0;
    r_data = 2'b10;
    for (int k = 1; k <= 60; k++) begin
      step();
      if (k_rise < 0 && r1_level[0]) k_rise = k;
      if (k_rise > 0 && k == k_rise + 6) r_data = 2'b11;
      if (r1_pulse[0]) hi1++;
      if (r0_pulse[0]) hi0++;
      if (r1_pulse[0] && !p1) up1++;
      if (r0_pulse[0] && !p0) up0++;
      p1 = r1_pulse[0];
      p0 = r0_pulse[0];
    end
    n_checks++;
    if (k_rise != 4) begin
      n_fail++;
      $display("FAIL retrig_rise_edge got=%0d want=4", k_rise);
    end
    n_checks++;
    if (hi1 != 30 || up1 != 1) begin
      n_fail++;
      $display("FAIL retrig_on_width got=%0d/%0d want=30/1", hi1, up1);
    end
    n_checks++;
    if (hi0 != 20 || up0 != 1) begin
      n_fail++;
      $display("FAIL retrig_off_width got=%0d/%0d want=20/1", hi0, up0);
    end
  endtask

  task automatic test_random();
    int hold[2] = '{0, 0};
    for (int k = 0; k < 600; k++) begin
      for (int c = 0; c < 2; c++) begin
        if (hold[c] == 0) begin
          data_in[c] = 1'($urandom_range(0, 1));
          hold[c] = $urandom_range(1, 14);
        end else begin
          hold[c]--;
        end
      end
      rise_en = 2'($urandom);
      fall_en = 2'($urandom);
      ev_clr  = ($urandom_range(0, 7) == 0) ? 2'($urandom) : 2'b00;
      step();
      n_checks++;
      if ({level_out, pulse_out, event_pending} !==
          {m_level_vec(), m_pulse_vec(), m_pend_vec()}) begin
        n_fail++;
        $display("FAIL rand_state cyc=%0d got=%b want=%b", k,
                 {level_out, pulse_out, event_pending},
                 {m_level_vec(), m_pulse_vec(), m_pend_vec()});
      end
      n_checks++;
      if (irq !== (|m_pend_vec())) begin
        n_fail++;
        $display("FAIL rand_irq cyc=%0d got=%b want=%b", k, irq, |m_pend_vec());
      end
    end
    rise_en = 2'b11;
    fall_en = 2'b11;
    ev_clr  = 2'b00;
  endtask

  task automatic test_reset_mid();
    data_in = 2'b11;
    for (int k = 0; k < 14; k++) step();
    data_in = 2'b10;
    for (int k = 0; k < 5; k++) step();
    data_in = 2'b00;
    for (int k = 0; k < 6; k++) step();
    n_checks++;
    if ({level_out, pulse_out} !== 4'b0101) begin
      n_fail++;
      $display("FAIL reset_mid_pre got=%b want=0101", {level_out, pulse_out});
    end
    #3 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({level_out, pulse_out, event_pending, irq} !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_mid_async got=%b want=0", {level_out, pulse_out, event_pending, irq});
    end
    step();
    step();
    #3 rst_n = 1'b1;
    for (int n = 1; n <= 13; n++) begin
      step();
      n_checks++;
      if (level_out !== {2{logic'(n >= 10)}}) begin
        n_fail++;
        $display("FAIL reset_mid_level edge=%0d got=%b", n, level_out);
      end
      n_checks++;
      if ({pulse_out, event_pending} !== {m_pulse_vec(), m_pend_vec()} ||
          pulse_out !== {2{logic'(n >= 10 && n <= 12)}}) begin
        n_fail++;
        $display("FAIL reset_mid_pulse edge=%0d got=%b/%b", n, pulse_out, event_pending);
      end
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_disabled_fall();
    test_bounce();
    test_clear();
    test_retrigger();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
